// File: rtl/hash_seq_pkg.sv
// Shared types and helpers for the hash memory sequencer: state encoding,
// hash geometry and the word-slice accessor used on packed hash vectors.
package hash_seq_pkg;

  localparam int unsigned HASH_WORDS    = 8;
  localparam int unsigned WORD_WIDTH    = 32;
  localparam int unsigned HASH_WIDTH    = HASH_WORDS * WORD_WIDTH;
  localparam int unsigned IDX_WIDTH     = $clog2(HASH_WORDS);
  localparam int unsigned BIT_SEL_WIDTH = $clog2(HASH_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_DRAIN,
    READY,
    STORE,
    DONE
  } state_t;

  // Word k of a packed hash vector lives at bits [32k+31:32k].
  function automatic logic [WORD_WIDTH-1:0] word_slice(
    input logic [HASH_WIDTH-1:0] vec,
    input logic [IDX_WIDTH-1:0]  idx
  );
    return vec[BIT_SEL_WIDTH'(idx) * BIT_SEL_WIDTH'(WORD_WIDTH) +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/hash_word_buffer.sv
// 256-bit hash register with a single word-indexed write port and a
// synchronous clear.
module hash_word_buffer
  import hash_seq_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [IDX_WIDTH-1:0]  index,
  input  logic [WORD_WIDTH-1:0] data,
  output logic [HASH_WIDTH-1:0] vector
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      vector <= '0;
    end else if (write_enable) begin
      vector[BIT_SEL_WIDTH'(index) * BIT_SEL_WIDTH'(WORD_WIDTH) +: WORD_WIDTH] <= data;
    end
  end

endmodule

// File: rtl/hash_mem_sequencer.sv
// Sequences the hash register between memory and the compression core: loads
// H0..H7, folds in the working variables and writes the result words back.
module hash_mem_sequencer
  import hash_seq_pkg::*;
#(
  parameter int unsigned HASH_LENGTH    = HASH_WORDS,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned HASH_BASE_ADDR = 0,
  parameter int unsigned OUT_BASE_ADDR  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  store_start,
  input  logic [HASH_WIDTH-1:0] working_vector,
  input  logic [WORD_WIDTH-1:0] hash_mem_read_data,
  output logic [ADDR_WIDTH-1:0] hash_mem_address,
  output logic                  hash_mem_write_enable,
  output logic [WORD_WIDTH-1:0] hash_mem_write_data,
  output logic [HASH_WIDTH-1:0] hash_vector,
  output logic                  hash_valid,
  output logic                  busy,
  output logic                  store_done
);

  localparam int unsigned          CNT_WIDTH = $clog2(HASH_LENGTH);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(HASH_LENGTH - 1);

  function automatic logic [ADDR_WIDTH-1:0] load_addr(input logic [CNT_WIDTH-1:0] idx);
    return ADDR_WIDTH'(HASH_BASE_ADDR + 32'(idx));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] out_addr(input logic [CNT_WIDTH-1:0] idx);
    return ADDR_WIDTH'(OUT_BASE_ADDR + 32'(idx));
  endfunction

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   count, count_nxt;
  logic [ADDR_WIDTH-1:0]  address_nxt;
  logic                   write_enable_nxt;
  logic [WORD_WIDTH-1:0]  write_data_nxt;
  logic                   valid_nxt;
  logic                   done_nxt;
  logic                   busy_nxt;

  logic                   buf_we;
  logic                   buf_clear;
  logic [CNT_WIDTH-1:0]   buf_idx;
  logic [WORD_WIDTH-1:0]  buf_data;

  // Write outputs are registered, so the sum is formed for the word about to
  // be presented: word 0 on entry to STORE, word count+1 while storing.
  logic [CNT_WIDTH-1:0]   sum_idx;
  logic [WORD_WIDTH-1:0]  sum;

  assign sum_idx = (state == STORE) ? CNT_WIDTH'(count + 1'b1) : '0;
  assign sum     = word_slice(hash_vector, IDX_WIDTH'(sum_idx))
                 + word_slice(working_vector, IDX_WIDTH'(sum_idx));

  hash_word_buffer u_buffer (
    .clock        (clock),
    .reset        (reset),
    .clear        (buf_clear),
    .write_enable (buf_we),
    .index        (IDX_WIDTH'(buf_idx)),
    .data         (buf_data),
    .vector       (hash_vector)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      count                 <= '0;
      hash_mem_address      <= '0;
      hash_mem_write_enable <= 1'b0;
      hash_mem_write_data   <= '0;
      hash_valid            <= 1'b0;
      busy                  <= 1'b0;
      store_done            <= 1'b0;
    end else begin
      state                 <= state_nxt;
      count                 <= count_nxt;
      hash_mem_address      <= address_nxt;
      hash_mem_write_enable <= write_enable_nxt;
      hash_mem_write_data   <= write_data_nxt;
      hash_valid            <= valid_nxt;
      busy                  <= busy_nxt;
      store_done            <= done_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    count_nxt        = count;
    address_nxt      = hash_mem_address;
    write_enable_nxt = 1'b0;
    write_data_nxt   = hash_mem_write_data;
    valid_nxt        = hash_valid;
    done_nxt         = 1'b0;
    busy_nxt         = 1'b0;
    buf_we           = 1'b0;
    buf_clear        = 1'b0;
    buf_idx          = count;
    buf_data         = hash_mem_read_data;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = LOAD;
          count_nxt   = '0;
          address_nxt = load_addr('0);
          valid_nxt   = 1'b0;
          buf_clear   = 1'b1;
        end
      end
      LOAD: begin
        // Read data lags the address by one cycle, so capture the previous word.
        if (count != '0) begin
          buf_we  = 1'b1;
          buf_idx = CNT_WIDTH'(count - 1'b1);
        end
        if (count == LAST_IDX) begin
          state_nxt = LOAD_DRAIN;
        end else begin
          count_nxt   = CNT_WIDTH'(count + 1'b1);
          address_nxt = load_addr(CNT_WIDTH'(count + 1'b1));
        end
      end
      LOAD_DRAIN: begin
        buf_we    = 1'b1;
        buf_idx   = LAST_IDX;
        state_nxt = READY;
        valid_nxt = 1'b1;
      end
      READY: begin
        if (store_start) begin
          state_nxt        = STORE;
          count_nxt        = '0;
          buf_we           = 1'b1;
          buf_idx          = '0;
          buf_data         = sum;
          write_enable_nxt = 1'b1;
          address_nxt      = out_addr('0);
          write_data_nxt   = sum;
        end else if (start) begin
          state_nxt   = LOAD;
          count_nxt   = '0;
          address_nxt = load_addr('0);
          valid_nxt   = 1'b0;
          buf_clear   = 1'b1;
        end
      end
      STORE: begin
        if (count == LAST_IDX) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          count_nxt        = sum_idx;
          buf_we           = 1'b1;
          buf_idx          = sum_idx;
          buf_data         = sum;
          write_enable_nxt = 1'b1;
          address_nxt      = out_addr(sum_idx);
          write_data_nxt   = sum;
        end
      end
      DONE: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == LOAD) || (state_nxt == LOAD_DRAIN) || (state_nxt == STORE);
  end

endmodule

// File: tb/tb_hash_mem_sequencer.sv
// Scoreboard bench for hash_mem_sequencer: a default instance and a 4-bit
// address instance run the same traffic against a word-array reference model.
module tb_hash_mem_sequencer;

  localparam int unsigned NW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, start, store_start;
  logic [255:0] working_vector;

  logic [31:0]  rd_main, rd_wrap;
  logic [15:0]  addr_main;
  logic [3:0]   addr_wrap;
  logic         we_main, we_wrap;
  logic [31:0]  wd_main, wd_wrap;
  logic [255:0] hv_main, hv_wrap;
  logic         valid_main, valid_wrap, busy_main, busy_wrap, done_main, done_wrap;

  logic [31:0]  mem [16];
  logic [31:0]  model_hash [NW];

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q_main[$];
  wr_t q_wrap[$];

  int checks = 0;
  int errors = 0;

  hash_mem_sequencer dut (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .store_start           (store_start),
    .working_vector        (working_vector),
    .hash_mem_read_data    (rd_main),
    .hash_mem_address      (addr_main),
    .hash_mem_write_enable (we_main),
    .hash_mem_write_data   (wd_main),
    .hash_vector           (hv_main),
    .hash_valid            (valid_main),
    .busy                  (busy_main),
    .store_done            (done_main)
  );

  hash_mem_sequencer #(
    .ADDR_WIDTH    (4),
    .OUT_BASE_ADDR (12)
  ) dut_wrap (
    .clock                 (clock),
    .reset                 (reset),
    .start                 (start),
    .store_start           (store_start),
    .working_vector        (working_vector),
    .hash_mem_read_data    (rd_wrap),
    .hash_mem_address      (addr_wrap),
    .hash_mem_write_enable (we_wrap),
    .hash_mem_write_data   (wd_wrap),
    .hash_vector           (hv_wrap),
    .hash_valid            (valid_wrap),
    .busy                  (busy_wrap),
    .store_done            (done_wrap)
  );

  // One-cycle read latency memory.
  always @(posedge clock) begin
    rd_main <= mem[addr_main[3:0]];
    rd_wrap <= mem[addr_wrap];
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    logic [7:0]   lsb;
    v = '0;
    for (int k = 0; k < NW; k++) begin
      lsb = 8'(32 * k);
      v[lsb +: 32] = model_hash[k];
    end
    return v;
  endfunction

  function automatic logic [31:0] word_of(input logic [255:0] v, input int k);
    logic [7:0] lsb;
    lsb = 8'(32 * k);
    return v[lsb +: 32];
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    logic [7:0]   lsb;
    v = '0;
    for (int k = 0; k < NW; k++) begin
      lsb = 8'(32 * k);
      v[lsb +: 32] = $urandom;
    end
    return v;
  endfunction

  // Write monitor: every write strobe must match the head of its queue.
  always @(negedge clock) begin
    wr_t e;
    if (we_main === 1'b1) begin
      checks++;
      if (q_main.size() == 0) begin
        errors++;
        $display("FAIL wr_main_unexpected: addr %h data %h with no write expected", addr_main, wd_main);
      end else begin
        e = q_main.pop_front();
        if (addr_main !== e.addr || wd_main !== e.data) begin
          errors++;
          $display("FAIL wr_main: got addr %h data %h expected addr %h data %h",
                   addr_main, wd_main, e.addr, e.data);
        end
      end
    end
    if (we_wrap === 1'b1) begin
      checks++;
      if (q_wrap.size() == 0) begin
        errors++;
        $display("FAIL wr_wrap_unexpected: addr %h data %h with no write expected", addr_wrap, wd_wrap);
      end else begin
        e = q_wrap.pop_front();
        if (addr_wrap !== e.addr[3:0] || wd_wrap !== e.data) begin
          errors++;
          $display("FAIL wr_wrap: got addr %h data %h expected addr %h data %h",
                   addr_wrap, wd_wrap, e.addr[3:0], e.data);
        end
      end
    end
  end

  task automatic check_reset_state();
    check("rst_vector", hv_main, '0);
    check("rst_valid", 256'(valid_main), 256'(0));
    check("rst_busy", 256'(busy_main), 256'(0));
    check("rst_done", 256'(done_main), 256'(0));
    check("rst_we", 256'(we_main), 256'(0));
    check("rst_addr", 256'(addr_main), 256'(0));
    check("rst_wdata", 256'(wd_main), 256'(0));
    check("rst_wrap_vector", hv_wrap, '0);
    check("rst_wrap_valid", 256'(valid_wrap), 256'(0));
    check("rst_wrap_we", 256'(we_wrap), 256'(0));
  endtask

  // Called at a negedge with the DUTs idle or READY.
  task automatic do_load();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      check("load_addr", 256'(addr_main), 256'(k));
      check("load_wrap_addr", 256'(addr_wrap), 256'(4'(k)));
      check("load_valid_low", 256'(valid_main), 256'(0));
      check("load_busy", 256'(busy_main), 256'(1));
      @(negedge clock);
    end
    check("drain_valid_low", 256'(valid_main), 256'(0));
    @(negedge clock);
    for (int k = 0; k < NW; k++) model_hash[k] = mem[k];
    check("load_valid", 256'(valid_main), 256'(1));
    check("load_wrap_valid", 256'(valid_wrap), 256'(1));
    check("load_busy_low", 256'(busy_main), 256'(0));
    check("load_vector", hv_main, model_vec());
    check("load_wrap_vector", hv_wrap, model_vec());
  endtask

  // Store from READY; n_writes < NW aborts the store with a reset after that many writes.
  task automatic do_store(input logic [255:0] wv, input bit with_start, input int n_writes);
    logic [31:0] res;
    working_vector = wv;
    for (int k = 0; k < n_writes; k++) begin
      res = model_hash[k] + word_of(wv, k);
      q_main.push_back('{16'(16 + k), res});
      q_wrap.push_back('{16'((12 + k) % 16), res});
      model_hash[k] = res;
    end
    store_start = 1'b1;
    start       = with_start;
    @(negedge clock);
    store_start = 1'b0;
    for (int k = 0; k < n_writes; k++) begin
      check("store_we", 256'(we_main), 256'(1));
      check("store_busy", 256'(busy_main), 256'(1));
      check("store_valid", 256'(valid_main), 256'(1));
      check("store_done_low", 256'(done_main), 256'(0));
      if (k == 3) start = 1'b0;
      if (k == n_writes - 1 && n_writes < NW) reset = 1'b1;
      @(negedge clock);
    end
    start = 1'b0;
    if (n_writes < NW) begin
      reset = 1'b0;
      for (int k = 0; k < NW; k++) model_hash[k] = '0;
      check_reset_state();
    end else begin
      check("store_done", 256'(done_main), 256'(1));
      check("store_wrap_done", 256'(done_wrap), 256'(1));
      check("done_busy_low", 256'(busy_main), 256'(0));
      check("done_we_low", 256'(we_main), 256'(0));
      check("done_valid", 256'(valid_main), 256'(1));
      @(negedge clock);
      check("store_done_pulse", 256'(done_main), 256'(0));
      check("store_vector", hv_main, model_vec());
      check("store_wrap_vector", hv_wrap, model_vec());
      check("ready_valid", 256'(valid_main), 256'(1));
    end
  endtask

  initial begin
    logic [255:0] wv;
    reset          = 1'b1;
    start          = 1'b0;
    store_start    = 1'b0;
    working_vector = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    mem[0] = 32'h6a09e667; mem[1] = 32'hbb67ae85; mem[2] = 32'h3c6ef372; mem[3] = 32'ha54ff53a;
    mem[4] = 32'h510e527f; mem[5] = 32'h9b05688c; mem[6] = 32'h1f83d9ab; mem[7] = 32'h5be0cd19;
    for (int k = 0; k < NW; k++) model_hash[k] = '0;

    repeat (2) @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    @(negedge clock);

    do_load();
    check("iv_word0", 256'(hv_main[31:0]), 256'(32'h6a09e667));
    check("iv_word7", 256'(hv_main[255:224]), 256'(32'h5be0cd19));

    // Carry out of word 0 is discarded.
    wv = '0;
    wv[31:0] = 32'hffffffff;
    for (int k = 1; k < NW; k++) wv[8'(32 * k) +: 32] = 32'h1;
    do_store(wv, 1'b0, NW);
    check("carry_word0", 256'(hv_main[31:0]), 256'(32'h6a09e666));
    check("carry_word1", 256'(hv_main[63:32]), 256'(32'hbb67ae86));

    repeat (2) @(negedge clock);
    do_store('0, 1'b0, NW);

    do_store(rand_vec(), 1'b1, NW);

    do_store(rand_vec(), 1'b0, 3);
    repeat (2) @(negedge clock);
    check("post_reset_idle_valid", 256'(valid_main), 256'(0));
    do_load();

    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < NW; k++) mem[k] = $urandom;
        do_load();
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      do_store(rand_vec(), 1'($urandom_range(0, 1)), NW);
    end

    repeat (2) @(negedge clock);
    check("queue_main_empty", 256'(q_main.size()), 256'(0));
    check("queue_wrap_empty", 256'(q_wrap.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_mem_sequencer.md
# hash_mem_sequencer

Controller that sequences the 256-bit hash register between the message memory and the compression core. It fetches the eight 32-bit initial hash words (H0..H7) from memory into a packed vector. It later folds the compression core's working variables into that vector (per-word modulo-2^32 add) and writes the eight result words back to memory. It sits between the memory port and the compression round logic and owns the hash vector the core reads.

## Interface
- HASH_LENGTH, 8, number of 32-bit hash words
- ADDR_WIDTH, 16, memory address width
- HASH_BASE_ADDR, 0, address of initial hash word 0
- OUT_BASE_ADDR, 16, address where result word 0 is written

Ports (one clock; reset is synchronous and active-high):
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; dominates all other inputs
- start  input  1  pulse: load initial hash from memory
- store_start  input  1  pulse: fold working_vector into hash and write back
- working_vector  input  256  compression core working variables a..h, word k at [32k+31:32k]; sampled while in STORE
- hash_mem_read_data  input  32  read data, valid one cycle after address
- hash_mem_address  output  ADDR_WIDTH  memory address
- hash_mem_write_enable  output  1  write strobe
- hash_mem_write_data  output  32  write data
- hash_vector  output  256  current hash, word k at [32k+31:32k]
- hash_valid  output  1  hash_vector holds a complete hash
- busy  output  1  high in LOAD, LOAD_DRAIN, STORE
- store_done  output  1  one-cycle pulse when last result word is written

## Operation
- States: IDLE, LOAD, LOAD_DRAIN, READY, STORE, DONE.
- IDLE: start=1 -> LOAD, word counter = 0, hash_valid cleared.
- LOAD: drive hash_mem_address = HASH_BASE_ADDR + counter. Capture hash_mem_read_data into word counter-1 when counter>0. Increment counter. After presenting address HASH_LENGTH-1 -> LOAD_DRAIN.
- LOAD_DRAIN: capture word HASH_LENGTH-1 -> READY, hash_valid=1.
- READY: store_start=1 -> STORE, counter=0. Else start=1 -> LOAD (reload). store_start wins if both are high.
- STORE: sum = hash word[counter] + working_vector word[counter], mod 2^32 (carry discarded). hash_mem_write_enable=1, hash_mem_address = OUT_BASE_ADDR + counter, hash_mem_write_data = sum. The same sum is written into hash_vector word[counter] so multi-block chaining works. After word HASH_LENGTH-1 -> DONE.
- DONE: store_done=1 for one cycle -> READY; hash_valid stays 1.
- start is ignored in LOAD, LOAD_DRAIN, STORE and DONE. store_start is ignored outside READY.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: hash_vector=0, hash_valid=0, busy=0, store_done=0, hash_mem_write_enable=0, hash_mem_address=0, hash_mem_write_data=0, state IDLE, counter 0.
- Reset mid-LOAD or mid-STORE: on that edge, return to IDLE with all outputs at reset values. A partially written result is abandoned; write_enable is low the cycle after the reset edge.
- Memory read latency is fixed at 1 cycle.
- Load latency: addresses are issued in the 8 cycles following the start edge. hash_valid rises at the 10th rising edge after the edge that samples start.
- Store: 8 consecutive write cycles starting the cycle after the store_start edge, then store_done in the 9th. READY is re-entered on the 10th edge.
- working_vector must be held stable from store_start through the last STORE cycle.
- Counter width is $clog2(HASH_LENGTH).

## Structure
- Shared package hash_seq_pkg: state enum, HASH_WORDS=8, WORD_WIDTH=32, word-slice helper (word k -> bits [32k+31:32k]).
- One sub-module, hash_word_buffer: 256-bit register with a word-indexed write port (index, 32-bit data, write enable) and synchronous clear.
- FSM, counter and adder stay in hash_mem_sequencer.

## Test plan
- Load: memory holds 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19 at 0..7. Pulse start -> addresses 0..7 on consecutive cycles; hash_valid at edge 10; hash_vector[31:0]=6a09e667 and [255:224]=5be0cd19.
- Store with wrap: after load, working word0=ffffffff, others 1 -> writes at 16..23; word0 = 6a09e666 (carry dropped), word1 = bb67ae86; store_done one cycle; hash_vector updated.
- Chaining: second store_start from READY with working_vector=0 -> written words equal the previous results; hash_valid stays 1.
- Simultaneous: start and store_start high together in READY -> STORE taken, no read addresses issued. start during STORE is ignored.
- Reset mid-STORE after 3 writes -> next cycle write_enable=0, hash_valid=0, hash_vector=0, IDLE; a later start reloads correctly.
- Address wrap: ADDR_WIDTH=4, OUT_BASE_ADDR=12 -> write addresses 12,13,14,15,0,1,2,3.
